// File: rtl/reg_bank_pkg.sv
// Shared CPU definitions: datapath width, register indices, $sp reset value and
// the write-back destination-select encodings used by the decode mux and the bench.
package reg_bank_pkg;

    localparam int DATA_W       = 32;
    localparam int REG_IDX_W    = 5;
    localparam int NUM_REGS     = 1 << REG_IDX_W;
    localparam int NUM_RD_PORTS = 2;
    localparam int SP_INIT      = 227;

    typedef logic [REG_IDX_W-1:0] regIdx_t;

    localparam regIdx_t REG_ZERO = 5'd0;
    localparam regIdx_t REG_SP   = 5'd29;
    localparam regIdx_t REG_RA   = 5'd31;

    typedef enum logic [1:0] {
        DST_RT = 2'b00,
        DST_RD = 2'b01,
        DST_RA = 2'b10,
        DST_SP = 2'b11
    } dstSel_e;

    // Write-side control as seen by every read port for the bypass compare.
    typedef struct packed {
        logic    en;
        regIdx_t idx;
    } wrCtl_t;

    function automatic regIdx_t dstMux(input dstSel_e sel, input regIdx_t rt, input regIdx_t rd);
        regIdx_t idx;
        case (sel)
            DST_RT:  idx = rt;
            DST_RD:  idx = rd;
            DST_RA:  idx = REG_RA;
            default: idx = REG_SP;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/reg_bank_read_port.sv
// One combinational read port: index decode, register-0 force and same-cycle
// write forwarding.
module reg_read_port
    import reg_bank_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NREGS  = 32,
    parameter bit BYPASS = 1'b1
) (
    input  logic [NREGS-1:0][WIDTH-1:0] bank,
    input  regIdx_t                     rdIdx,
    input  wrCtl_t                      wr,
    input  logic [WIDTH-1:0]            wrData,
    output logic [WIDTH-1:0]            rdData
);

    logic hit;

    // wr.en already excludes index 0 and reset, so only the index compare is left.
    assign hit = BYPASS && wr.en && (wr.idx == rdIdx);

    always_comb begin
        rdData = bank[rdIdx];
        if (hit)
            rdData = wrData;
        if (rdIdx == REG_ZERO)
            rdData = '0;
    end

endmodule

// File: rtl/reg_bank.sv
// 32-entry register file, one write port and two combinational read ports,
// with an asynchronously reset bank ($sp resets to SP_INIT, all others to 0).
module reg_bank #(
    parameter int DATA_W  = reg_bank_pkg::DATA_W,
    parameter int SP_INIT = reg_bank_pkg::SP_INIT,
    parameter bit BYPASS  = 1'b1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              reg_write,
    input  logic [reg_bank_pkg::REG_IDX_W-1:0] write_reg,
    input  logic [DATA_W-1:0]                 write_data,
    input  logic [reg_bank_pkg::REG_IDX_W-1:0] read_reg1,
    input  logic [reg_bank_pkg::REG_IDX_W-1:0] read_reg2,
    output logic [DATA_W-1:0]                 read_data1,
    output logic [DATA_W-1:0]                 read_data2
);
    import reg_bank_pkg::*;

    localparam logic [DATA_W-1:0] SP_RST = DATA_W'(SP_INIT);

    logic   [NUM_REGS-1:0][DATA_W-1:0]     bank;
    wrCtl_t                                wr;
    logic   [NUM_RD_PORTS-1:0][REG_IDX_W-1:0] rdIdx;
    logic   [NUM_RD_PORTS-1:0][DATA_W-1:0]    rdData;

    // Reset masks the write entirely, which also disables forwarding.
    always_comb begin
        wr.en  = reg_write && !reset && (write_reg != REG_ZERO);
        wr.idx = write_reg;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                bank[i] <= (i == int'(REG_SP)) ? SP_RST : '0;
        end else if (wr.en) begin
            bank[wr.idx] <= write_data;
        end
    end

    assign rdIdx[0]   = read_reg1;
    assign rdIdx[1]   = read_reg2;
    assign read_data1 = rdData[0];
    assign read_data2 = rdData[1];

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
        reg_read_port #(
            .WIDTH  (DATA_W),
            .NREGS  (NUM_REGS),
            .BYPASS (BYPASS)
        ) u_port (
            .bank   (bank),
            .rdIdx  (rdIdx[p]),
            .wr     (wr),
            .wrData (write_data),
            .rdData (rdData[p])
        );
    end

endmodule

// File: tb/tb_reg_bank.sv
// Directed and random checks of reg_bank, with forwarding on (dut) and off (dutNb).
module tb_reg_bank;
    import reg_bank_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [4:0]  read_reg1, read_reg2;
    logic [31:0] rd1, rd2, nb1, nb2;

    int nTests = 0;
    int nFail  = 0;

    always #5 clk = ~clk;

    reg_bank #(.DATA_W(32), .SP_INIT(227), .BYPASS(1'b1)) dut (
        .clk(clk), .reset(reset), .reg_write(reg_write), .write_reg(write_reg),
        .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
        .read_data1(rd1), .read_data2(rd2)
    );

    reg_bank #(.DATA_W(32), .SP_INIT(227), .BYPASS(1'b0)) dutNb (
        .clk(clk), .reset(reset), .reg_write(reg_write), .write_reg(write_reg),
        .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
        .read_data1(nb1), .read_data2(nb2)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wIdx;
        logic [31:0] wData;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] e1, e2;   // forwarding on
        logic [31:0] n1, n2;   // forwarding off
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [4:0] wi, input logic [31:0] wd,
                         input logic [4:0] r1, input logic [4:0] r2);
        reg_write  = we;
        write_reg  = wi;
        write_data = wd;
        read_reg1  = r1;
        read_reg2  = r2;
    endtask

    logic [31:0] m [32];

    initial begin
        //           we   idx    data          r1  r2  e1            e2            n1            n2
        vecs[0]  = '{1'b1, 5'd8,  32'hDEADBEEF, 5'd8,  5'd9,  32'hDEADBEEF, 32'h0,        32'h0,        32'h0};
        vecs[1]  = '{1'b0, 5'd8,  32'h0,        5'd8,  5'd8,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0};
        vecs[3]  = '{1'b0, 5'd0,  32'h12345678, 5'd0,  5'd8,  32'h0,        32'hDEADBEEF, 32'h0,        32'hDEADBEEF};
        vecs[4]  = '{1'b1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd29, 32'hA5A5A5A5, 32'd227,      32'h0,        32'd227};
        vecs[5]  = '{1'b0, 5'd31, 32'h0,        5'd31, 5'd31, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5};
        vecs[6]  = '{1'b1, 5'd29, 32'h00001000, 5'd29, 5'd29, 32'h00001000, 32'h00001000, 32'd227,      32'd227};
        vecs[7]  = '{1'b0, 5'd29, 32'h0,        5'd29, 5'd1,  32'h00001000, 32'h0,        32'h00001000, 32'h0};
        vecs[8]  = '{1'b1, 5'd5,  32'h00000055, 5'd6,  5'd5,  32'h0,        32'h00000055, 32'h0,        32'h0};
        vecs[9]  = '{1'b1, 5'd6,  32'h00000066, 5'd5,  5'd6,  32'h00000055, 32'h00000066, 32'h00000055, 32'h0};
        vecs[10] = '{1'b0, 5'd6,  32'h0,        5'd6,  5'd0,  32'h00000066, 32'h0,        32'h00000066, 32'h0};

        reset = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        #2;

        // Reset contents, with a write attempted to the same index (must be ignored, no forwarding)
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 5'(i), 32'hFFFFFFFF, 5'(i), 5'(i));
            #2;
            check($sformatf("rst_rd1[%0d]", i), rd1, (i == 29) ? 32'd227 : 32'd0);
            check($sformatf("rst_rd2[%0d]", i), rd2, (i == 29) ? 32'd227 : 32'd0);
            check($sformatf("rst_nb1[%0d]", i), nb1, (i == 29) ? 32'd227 : 32'd0);
        end
        reg_write = 1'b0;
        tick();
        reset = 1'b0;

        for (int v = 0; v < 11; v++) begin
            drive(vecs[v].we, vecs[v].wIdx, vecs[v].wData, vecs[v].r1, vecs[v].r2);
            #3;
            check($sformatf("vec%0d_rd1", v), rd1, vecs[v].e1);
            check($sformatf("vec%0d_rd2", v), rd2, vecs[v].e2);
            check($sformatf("vec%0d_nb1", v), nb1, vecs[v].n1);
            check($sformatf("vec%0d_nb2", v), nb2, vecs[v].n2);
            tick();
        end

        // Asynchronous reset in the middle of a write to $sp
        drive(1'b1, 5'd29, 32'hFFFFFFFF, 5'd29, 5'd8);
        #2;
        check("midrst_pre_byp", rd1, 32'hFFFFFFFF);
        check("midrst_pre_nb", nb1, 32'h00001000);
        reset = 1'b1;
        #1;
        check("midrst_sp_now", rd1, 32'd227);
        check("midrst_sp_now_nb", nb1, 32'd227);
        check("midrst_r8_now", rd2, 32'h0);
        tick();
        check("midrst_sp_held", rd1, 32'd227);
        reg_write = 1'b0;
        reset = 1'b0;
        #2;
        check("midrst_sp_rel", rd1, 32'd227);
        tick();
        check("midrst_sp_after", nb1, 32'd227);

        // First write after reset release lands on the first edge
        drive(1'b1, 5'd3, 32'h00000033, 5'd3, 5'd0);
        #2;
        check("first_wr_byp", rd1, 32'h00000033);
        check("first_wr_nb_old", nb1, 32'h0);
        tick();
        reg_write = 1'b0;
        #2;
        check("first_wr_nb_new", nb1, 32'h00000033);
        check("first_wr_r0", rd2, 32'h0);

        // Random traffic against a reference model
        reset = 1'b1;
        #2;
        reset = 1'b0;
        for (int i = 0; i < 32; i++) m[i] = (i == 29) ? 32'd227 : 32'd0;
        for (int c = 0; c < 10000; c++) begin
            logic [4:0]  wi, r1, r2;
            logic [31:0] wd, e1, e2;
            logic        we;
            tick();
            we = 1'($urandom_range(0, 1));
            wi = dstMux(dstSel_e'($urandom_range(0, 3)), 5'($urandom), 5'($urandom));
            wd = $urandom;
            r1 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            r2 = ($urandom_range(0, 3) == 0) ? wi : 5'($urandom);
            drive(we, wi, wd, r1, r2);
            #3;
            e1 = (r1 == 0) ? 32'h0 : (we && wi != 0 && wi == r1) ? wd : m[r1];
            e2 = (r2 == 0) ? 32'h0 : (we && wi != 0 && wi == r2) ? wd : m[r2];
            check("rnd_rd1", rd1, e1);
            check("rnd_rd2", rd2, e2);
            check("rnd_nb1", nb1, (r1 == 0) ? 32'h0 : m[r1]);
            check("rnd_nb2", nb2, (r2 == 0) ? 32'h0 : m[r2]);
            if (we && wi != 0) m[wi] = wd;
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
